// File: rtl/mem_bus_if_if.sv
// External single-beat req/ack bus between the core's memory port and a slave.
// The master drives the request side; the slave answers with ack and read data.
interface mem_bus_if_if #(
    parameter int RV = 32,
    parameter int VA = RV
);
    logic                 bus_req;
    logic                 bus_we;
    logic                 bus_io;
    logic [VA-1:RV/16]    bus_addr;
    logic [RV/8-1:0]      bus_be;
    logic [RV-1:0]        bus_wdata;
    logic                 bus_ack;
    logic [RV-1:0]        bus_rdata;
    logic                 bus_err;

    modport master (
        output bus_req, bus_we, bus_io, bus_addr, bus_be, bus_wdata, bus_err,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_io, bus_addr, bus_be, bus_wdata, bus_err,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_bus_if.sv
// Arbitrates held-level store/load/fetch requests onto one req/ack bus, with timeout abort.
// Request-to-done is ack cycle + 1 (minimum 2); requesters hold their level until done.
module mem_bus_if #(
    parameter int RV      = 32,
    parameter int VA      = RV,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [VA-1:1]     pc,
    input  logic              ifetch,
    input  logic [VA-1:RV/16] addr,
    input  logic [1:0]        baddr_lo,
    input  logic [1:0]        rstrobe,
    input  logic [RV/8-1:0]   wmask,
    input  logic [RV-1:0]     wdata,
    input  logic              io_access,
    output logic              idone,
    output logic              rdone,
    output logic              wdone,
    output logic [RV-1:0]     rdata,
    output logic [15:0]       insn,
    mem_bus_if_if.master      bus
);
    localparam int LW = RV / 16;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [1:0]          kind_q, kind_d;
    logic                byte_q, byte_d;
    logic [LW-1:0]       bsel_q, bsel_d;
    logic                hsel_q, hsel_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic                io_q, io_d;
    logic [VA-1:RV/16]   addr_q, addr_d;
    logic [RV/8-1:0]     be_q, be_d;
    logic [RV-1:0]       wdat_q, wdat_d;
    logic                idone_q, idone_d;
    logic                rdone_q, rdone_d;
    logic                wdone_q, wdone_d;
    logic                err_q, err_d;
    logic [RV-1:0]       rdata_q, rdata_d;
    logic [15:0]         insn_q, insn_d;

    logic                finish;
    logic                abort;
    logic [RV-1:0]       lane_sh;
    logic [15:0]         parcel;

    always_comb begin
        lane_sh = bus.bus_rdata >> {bsel_q, 3'b000};
        parcel  = (RV == 32 && hsel_q) ? bus.bus_rdata[RV-1 -: 16] : bus.bus_rdata[15:0];

        state_d = state_q;
        kind_d  = kind_q;
        byte_d  = byte_q;
        bsel_d  = bsel_q;
        hsel_d  = hsel_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        io_d    = io_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdat_d  = wdat_q;
        idone_d = 1'b0;
        rdone_d = 1'b0;
        wdone_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        insn_d  = insn_q;
        finish  = 1'b0;
        abort   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|wmask) begin
                    kind_d = K_STORE;
                    we_d   = 1'b1;
                    be_d   = wmask;
                    addr_d = addr;
                    io_d   = io_access;
                    wdat_d = wdata;
                end else if (|rstrobe) begin
                    kind_d = K_LOAD;
                    we_d   = 1'b0;
                    be_d   = '1;
                    addr_d = addr;
                    io_d   = io_access;
                    byte_d = (rstrobe != 2'b11);
                    bsel_d = baddr_lo[LW-1:0];
                end else if (ifetch) begin
                    kind_d = K_FETCH;
                    we_d   = 1'b0;
                    be_d   = '1;
                    addr_d = pc[VA-1:RV/16];
                    io_d   = 1'b0;
                    hsel_d = pc[1];
                end
                if ((|wmask) || (|rstrobe) || ifetch) begin
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // An ack landing on the expiry cycle wins over the timeout.
                if (bus.bus_ack) begin
                    finish = 1'b1;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (finish) begin
                    req_d   = 1'b0;
                    err_d   = abort;
                    state_d = S_DONE;
                    case (kind_q)
                        K_FETCH: begin
                            idone_d = 1'b1;
                            insn_d  = abort ? 16'hFFFF : parcel;
                        end
                        K_LOAD: begin
                            rdone_d = 1'b1;
                            if (abort)       rdata_d = '1;
                            else if (byte_q) rdata_d = {{(RV-8){1'b0}}, lane_sh[7:0]};
                            else             rdata_d = bus.bus_rdata;
                        end
                        default: wdone_d = 1'b1;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            kind_q  <= K_FETCH;
            byte_q  <= 1'b0;
            bsel_q  <= '0;
            hsel_q  <= 1'b0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdat_q  <= '0;
            idone_q <= 1'b0;
            rdone_q <= 1'b0;
            wdone_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            insn_q  <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            byte_q  <= byte_d;
            bsel_q  <= bsel_d;
            hsel_q  <= hsel_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            io_q    <= io_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdat_q  <= wdat_d;
            idone_q <= idone_d;
            rdone_q <= rdone_d;
            wdone_q <= wdone_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            insn_q  <= insn_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_io    = io_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdat_q;
    assign bus.bus_err   = err_q;
    assign idone         = idone_q;
    assign rdone         = rdone_q;
    assign wdone         = wdone_q;
    assign rdata         = rdata_q;
    assign insn          = insn_q;
endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: directed scenarios plus randomized transactions against a
// transaction-level model (priority, latency from ack delay, timeout, data lanes).
module tb_mem_bus_if;
    localparam int RV = 32;
    localparam int VA = 32;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:1] pc = '0;
    logic        ifetch = 1'b0;
    logic [31:2] addr = '0;
    logic [1:0]  baddr_lo = '0;
    logic [1:0]  rstrobe = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;
    logic        io_access = 1'b0;
    logic        idone, rdone, wdone;
    logic [31:0] rdata;
    logic [15:0] insn;

    mem_bus_if_if #(.RV(RV), .VA(VA)) bus ();

    mem_bus_if #(.RV(RV), .VA(VA), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .ifetch    (ifetch),
        .addr      (addr),
        .baddr_lo  (baddr_lo),
        .rstrobe   (rstrobe),
        .wmask     (wmask),
        .wdata     (wdata),
        .io_access (io_access),
        .idone     (idone),
        .rdone     (rdone),
        .wdone     (wdone),
        .rdata     (rdata),
        .insn      (insn),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations of the last transaction
    logic [31:2] obs_addr;
    logic [3:0]  obs_be;
    logic        obs_we, obs_io, obs_req1;
    logic [31:0] obs_wdata, obs_rdata;
    logic [15:0] obs_insn;
    logic [2:0]  obs_vec;
    logic        obs_err_at_done, obs_extra;
    int          obs_req_cycles, obs_done_cycle, obs_err_cnt;

    // Model expectations
    logic [31:2] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we, exp_io, exp_err;
    logic [2:0]  exp_vec;
    int          exp_req_cycles, exp_done_cycle;
    logic [31:0] last_rdata = '0;
    logic [15:0] last_insn = '0;

    task automatic model_txn(input logic [3:0] wm, input logic [1:0] rs, input logic fe,
                             input logic [31:2] a, input logic [1:0] blo, input logic [31:1] pcv,
                             input logic io, input int ack_d, input logic [31:0] rd);
        logic [31:0] byte_addr;
        logic        tmo;
        tmo = (ack_d + 1 > TO);
        exp_err = tmo;
        exp_req_cycles = tmo ? TO : ack_d + 1;
        exp_done_cycle = tmo ? TO + 1 : ack_d + 2;
        if (wm != 0) begin
            exp_vec = 3'b001; exp_we = 1'b1; exp_be = wm; exp_addr = a; exp_io = io;
        end else if (rs != 0) begin
            exp_vec = 3'b010; exp_we = 1'b0; exp_be = 4'hF; exp_addr = a; exp_io = io;
            if (tmo)            last_rdata = 32'hFFFF_FFFF;
            else if (rs == 2'b11) last_rdata = rd;
            else                last_rdata = (rd >> (8 * int'(blo))) & 32'hFF;
        end else begin
            exp_vec = 3'b100; exp_we = 1'b0; exp_be = 4'hF; exp_io = 1'b0;
            byte_addr = {pcv, 1'b0};
            exp_addr = 30'(byte_addr / 4);
            if (tmo)                    last_insn = 16'hFFFF;
            else if (byte_addr % 4 == 2) last_insn = rd[31:16];
            else                        last_insn = rd[15:0];
        end
        if (fe === 1'bx) exp_vec = 3'bxxx;
    endtask

    task automatic drive_txn(input logic [3:0] wm, input logic [1:0] rs, input logic fe,
                             input logic [31:2] a, input logic [1:0] blo, input logic [31:1] pcv,
                             input logic io, input logic [31:0] wd, input int ack_d,
                             input logic [31:0] rd);
        wmask = wm; rstrobe = rs; ifetch = fe; addr = a; baddr_lo = blo;
        pc = pcv; io_access = io; wdata = wd;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        obs_req_cycles = 0; obs_done_cycle = -1; obs_err_cnt = 0;
        obs_err_at_done = 1'b0; obs_vec = 3'b000;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                obs_addr = bus.bus_addr; obs_be = bus.bus_be; obs_we = bus.bus_we;
                obs_io = bus.bus_io; obs_wdata = bus.bus_wdata; obs_req1 = bus.bus_req;
            end
            if (bus.bus_req) obs_req_cycles++;
            if (bus.bus_err) obs_err_cnt++;
            if (idone | rdone | wdone) begin
                obs_done_cycle = c;
                obs_vec = {idone, rdone, wdone};
                obs_err_at_done = bus.bus_err;
                break;
            end
            bus.bus_ack = (c == ack_d + 1);
            bus.bus_rdata = rd;
        end
        wmask = '0; rstrobe = '0; ifetch = 1'b0; bus.bus_ack = 1'b0;
        @(negedge clk);
        obs_extra = idone | rdone | wdone | bus.bus_req | bus.bus_err;
        obs_rdata = rdata;
        obs_insn = insn;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.bus_req, bus.bus_we, bus.bus_io, bus.bus_err} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000", {bus.bus_req, bus.bus_we, bus.bus_io, bus.bus_err});
        end
        checks++;
        if ({bus.bus_addr, bus.bus_be, bus.bus_wdata} !== '0) begin
            errors++; $display("FAIL reset_bus got %h/%h/%h want 0", bus.bus_addr, bus.bus_be, bus.bus_wdata);
        end
        checks++;
        if ({idone, rdone, wdone, rdata, insn} !== '0) begin
            errors++; $display("FAIL reset_outs got done=%b rdata=%h insn=%h want 0", {idone, rdone, wdone}, rdata, insn);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        model_txn(4'h0, 2'b00, 1'b1, '0, 2'd0, 31'h81, 1'b0, 1, 32'hBEEF1234);
        drive_txn(4'h0, 2'b00, 1'b1, '0, 2'd0, 31'h81, 1'b1, 32'h0, 1, 32'hBEEF1234);
        checks++;
        if (obs_addr !== 30'h40) begin errors++; $display("FAIL fetch_addr got %h want 40", obs_addr); end
        checks++;
        if ({obs_we, obs_io, obs_be} !== 6'b00_1111) begin
            errors++; $display("FAIL fetch_ctl got we=%b io=%b be=%h want 0 0 f", obs_we, obs_io, obs_be);
        end
        checks++;
        if (obs_done_cycle !== 3 || obs_vec !== 3'b100) begin
            errors++; $display("FAIL fetch_done got cycle %0d vec %b want 3 100", obs_done_cycle, obs_vec);
        end
        checks++;
        if (obs_insn !== 16'hBEEF) begin errors++; $display("FAIL fetch_insn got %h want beef", obs_insn); end
    endtask

    task automatic test_byte_load();
        model_txn(4'h0, 2'b01, 1'b0, 30'h123, 2'd2, '0, 1'b0, 0, 32'h00A50000);
        drive_txn(4'h0, 2'b01, 1'b0, 30'h123, 2'd2, '0, 1'b0, 32'h0, 0, 32'h00A50000);
        checks++;
        if (obs_done_cycle !== 2 || obs_vec !== 3'b010 || obs_extra !== 1'b0) begin
            errors++; $display("FAIL bload_done got cycle %0d vec %b extra %b want 2 010 0", obs_done_cycle, obs_vec, obs_extra);
        end
        checks++;
        if (obs_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL bload_rdata got %h want 000000a5", obs_rdata); end
        checks++;
        if (obs_insn !== 16'hBEEF) begin errors++; $display("FAIL bload_insn_hold got %h want beef", obs_insn); end
    endtask

    task automatic test_priority();
        model_txn(4'b0100, 2'b00, 1'b1, 30'h77, 2'd0, 31'h10, 1'b1, 2, 32'h0);
        drive_txn(4'b0100, 2'b00, 1'b1, 30'h77, 2'd0, 31'h10, 1'b1, 32'h5555_AAAA, 2, 32'h0);
        checks++;
        if ({obs_we, obs_be, obs_io} !== 6'b1_0100_1 || obs_addr !== 30'h77 || obs_wdata !== 32'h5555_AAAA) begin
            errors++; $display("FAIL prio_store got we=%b be=%b io=%b addr=%h wd=%h want 1 0100 1 77 5555aaaa",
                               obs_we, obs_be, obs_io, obs_addr, obs_wdata);
        end
        checks++;
        if (obs_vec !== 3'b001) begin errors++; $display("FAIL prio_wdone got %b want 001", obs_vec); end
        model_txn(4'h0, 2'b00, 1'b1, '0, 2'd0, 31'h10, 1'b0, 0, 32'h1111_2222);
        drive_txn(4'h0, 2'b00, 1'b1, '0, 2'd0, 31'h10, 1'b0, 32'h0, 0, 32'h1111_2222);
        checks++;
        if (obs_vec !== 3'b100 || obs_insn !== 16'h2222 || obs_addr !== 30'h8) begin
            errors++; $display("FAIL prio_fetch got vec %b insn %h addr %h want 100 2222 8", obs_vec, obs_insn, obs_addr);
        end
    endtask

    task automatic test_timeout();
        model_txn(4'h0, 2'b11, 1'b0, 30'h9, 2'd0, '0, 1'b0, 20, 32'h0);
        drive_txn(4'h0, 2'b11, 1'b0, 30'h9, 2'd0, '0, 1'b0, 32'h0, 20, 32'h0);
        checks++;
        if (obs_req_cycles !== 4 || obs_done_cycle !== 5) begin
            errors++; $display("FAIL tmo_timing got req %0d done %0d want 4 5", obs_req_cycles, obs_done_cycle);
        end
        checks++;
        if (obs_err_at_done !== 1'b1 || obs_err_cnt !== 1 || obs_vec !== 3'b010) begin
            errors++; $display("FAIL tmo_err got err %b cnt %0d vec %b want 1 1 010", obs_err_at_done, obs_err_cnt, obs_vec);
        end
        checks++;
        if (obs_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmo_rdata got %h want ffffffff", obs_rdata); end
    endtask

    task automatic test_ack_at_expiry();
        model_txn(4'h0, 2'b11, 1'b0, 30'h3, 2'd0, '0, 1'b0, 3, 32'hCAFE_F00D);
        drive_txn(4'h0, 2'b11, 1'b0, 30'h3, 2'd0, '0, 1'b0, 32'h0, 3, 32'hCAFE_F00D);
        checks++;
        if (obs_err_cnt !== 0 || obs_done_cycle !== 5 || obs_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL expiry_ack got err %0d done %0d rdata %h want 0 5 cafef00d",
                               obs_err_cnt, obs_done_cycle, obs_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        pc = 31'h40; ifetch = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL mid_async_drop got %b want 0", bus.bus_req); end
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (idone | rdone | wdone) dn++;
        end
        checks++;
        if (dn !== 0 || insn !== 16'h0) begin
            errors++; $display("FAIL mid_no_done got %0d dones insn %h want 0 0", dn, insn);
        end
        ifetch = 1'b0;
        reset = 1'b0;
        last_rdata = '0; last_insn = '0;
        model_txn(4'h0, 2'b00, 1'b1, '0, 2'd0, 31'h41, 1'b0, 1, 32'h7654_3210);
        drive_txn(4'h0, 2'b00, 1'b1, '0, 2'd0, 31'h41, 1'b0, 32'h0, 1, 32'h7654_3210);
        checks++;
        if (obs_vec !== 3'b100 || obs_done_cycle !== 3 || obs_insn !== 16'h7654 || obs_rdata !== 32'h0) begin
            errors++; $display("FAIL mid_fresh got vec %b cyc %0d insn %h rdata %h want 100 3 7654 0",
                               obs_vec, obs_done_cycle, obs_insn, obs_rdata);
        end
    endtask

    task automatic test_random();
        logic [3:0]  wm;
        logic [1:0]  rs, blo;
        logic        fe, io;
        logic [31:2] a;
        logic [31:1] pcv;
        logic [31:0] wd, rd;
        int          ack_d, k;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 3);
            wm = '0; rs = '0; fe = 1'($urandom);
            if (k == 0) begin wm = 4'($urandom_range(1, 15)); rs = 2'($urandom); end
            else if (k == 1) rs = 2'($urandom_range(1, 3));
            else fe = 1'b1;
            a = 30'($urandom); blo = 2'($urandom); pcv = 31'($urandom);
            io = 1'($urandom); wd = $urandom; rd = $urandom;
            ack_d = $urandom_range(0, 5);
            model_txn(wm, rs, fe, a, blo, pcv, io, ack_d, rd);
            drive_txn(wm, rs, fe, a, blo, pcv, io, wd, ack_d, rd);
            checks++;
            if (obs_req1 !== 1'b1 || obs_addr !== exp_addr || {obs_we, obs_io, obs_be} !== {exp_we, exp_io, exp_be}) begin
                errors++; $display("FAIL rnd_issue[%0d] got req %b addr %h we %b io %b be %h want 1 %h %b %b %h",
                                   i, obs_req1, obs_addr, obs_we, obs_io, obs_be, exp_addr, exp_we, exp_io, exp_be);
            end
            checks++;
            if (wm != 0 && obs_wdata !== wd) begin
                errors++; $display("FAIL rnd_wdata[%0d] got %h want %h", i, obs_wdata, wd);
            end
            checks++;
            if (obs_req_cycles !== exp_req_cycles || obs_done_cycle !== exp_done_cycle || obs_vec !== exp_vec) begin
                errors++; $display("FAIL rnd_timing[%0d] got req %0d done %0d vec %b want %0d %0d %b",
                                   i, obs_req_cycles, obs_done_cycle, obs_vec, exp_req_cycles, exp_done_cycle, exp_vec);
            end
            checks++;
            if (obs_err_at_done !== exp_err || obs_err_cnt !== int'(exp_err) || obs_extra !== 1'b0) begin
                errors++; $display("FAIL rnd_err[%0d] got err %b cnt %0d extra %b want %b", i,
                                   obs_err_at_done, obs_err_cnt, obs_extra, exp_err);
            end
            checks++;
            if (obs_rdata !== last_rdata || obs_insn !== last_insn) begin
                errors++; $display("FAIL rnd_data[%0d] got rdata %h insn %h want %h %h",
                                   i, obs_rdata, obs_insn, last_rdata, last_insn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_byte_load();
        test_priority();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
